sd_spi_master: RTL and testbench



---
 rtl/sd_spi_master.sv | 176 +++++++++++++++++
 tb/tb_sd_spi_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_master.sv
// sd_spi_master: byte-level SPI master (mode 0, MSB first) for the SD card pins.
// It exchanges a single byte, or runs a read burst in which the first byte
// transmitted is din and the remaining bytes are 0xFF fill. sdclk runs at one
// of two selectable divided rates. The block also sequences the chip select.
module sd_spi_master #(
    parameter int unsigned DIV_SLOW = 34,  // half-period minus 1, slow/init mode
    parameter int unsigned DIV_FAST = 0    // half-period minus 1, fast/data mode
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       cs_ctl,
    input  logic       speed,
    input  logic       start,
    input  logic [7:0] din,
    input  logic [9:0] cnt,
    input  logic       abort,
    output logic [7:0] dout,
    output logic       dout_stb,
    output logic       busy,
    output logic       sdcs_n,
    output logic       sdclk,
    output logic       sddo,
    input  logic       sddi
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [7:0] DIV_S = 8'(DIV_SLOW);
    localparam logic [7:0] DIV_F = 8'(DIV_FAST);

    logic [0:0] state_q, state_d;
    logic [7:0] hc_q, hc_d;        // half-period down-counter
    logic [7:0] div_q, div_d;      // reload value latched at start
    logic [7:0] tx_q, tx_d;        // transmit shifter, bit 7 is on sddo
    logic [7:0] rx_q, rx_d;        // receive shifter, fills from the LSB
    logic [2:0] bit_q, bit_d;      // falling edges seen in the current byte
    logic [9:0] bytes_q, bytes_d;  // bytes still to go after the current one
    logic [7:0] dout_q, dout_d;
    logic       stb_q, stb_d;
    logic       busy_q, busy_d;
    logic       cs_n_q, cs_n_d;
    logic       sdclk_q, sdclk_d;
    logic       sddo_q, sddo_d;

    logic       tick;       // half-period boundary: sdclk toggles this cycle
    logic       byte_done;  // 8th falling edge of the current byte

    assign tick      = (state_q == ST_SHIFT) && (hc_q == '0);
    assign byte_done = tick && sdclk_q && (bit_q == 3'd7);

    // Next-state logic for the transfer FSM, shifters and pin registers.
    always_comb begin
        // NOTE: every signal gets a default before any branch so that no
        // path leaves it unassigned; a missing default infers a latch.
        state_d  = state_q;
        hc_d     = hc_q;
        div_d    = div_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        bit_d    = bit_q;
        bytes_d  = bytes_q;
        dout_d   = dout_q;
        stb_d    = 1'b0;
        busy_d   = busy_q;
        cs_n_d   = cs_n_q;
        sdclk_d  = sdclk_q;
        sddo_d   = sddo_q;

        case (state_q)
            ST_IDLE: begin
                // Chip select only tracks cs_ctl between transfers, so a
                // change requested mid-burst lands on the first idle cycle.
                cs_n_d  = ~cs_ctl;
                sdclk_d = 1'b0;
                sddo_d  = 1'b1;
                if (start) begin
                    state_d = ST_SHIFT;
                    busy_d  = 1'b1;
                    tx_d    = din;
                    sddo_d  = din[7];
                    bytes_d = cnt;
                    bit_d   = 3'd0;
                    div_d   = speed ? DIV_F : DIV_S;
                    hc_d    = speed ? DIV_F : DIV_S;
                end
            end

            default: begin  // ST_SHIFT
                if (tick) begin
                    hc_d    = div_q;
                    sdclk_d = ~sdclk_q;
                    if (!sdclk_q) begin
                        // Rising edge: sample MISO.
                        rx_d = {rx_q[6:0], sddi};
                    end else if (bit_q == 3'd7) begin
                        // Final falling edge of the byte: publish it.
                        stb_d  = 1'b1;
                        dout_d = rx_q;
                        bit_d  = 3'd0;
                        if (bytes_q != '0 && !abort) begin
                            bytes_d = bytes_q - 10'd1;
                            tx_d    = 8'hFF;
                            sddo_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            sddo_d  = 1'b1;
                        end
                    end else begin
                        // Falling edge: present the next MOSI bit.
                        bit_d  = bit_q + 3'd1;
                        tx_d   = {tx_q[6:0], 1'b1};
                        sddo_d = tx_q[6];
                    end
                end else begin
                    hc_d = hc_q - 8'd1;
                end

                // Abort drops the partial byte; a coincident byte completion
                // was already handled above and ends the transfer itself.
                if (abort && !byte_done) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    sdclk_d = 1'b0;
                    sddo_d  = 1'b1;
                    bit_d   = 3'd0;
                    hc_d    = '0;
                end
            end
        endcase
    end

    // State register; async reset returns the pins to their idle levels.
    always_ff @(posedge fclk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before this clock edge.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hc_q    <= '0;
            div_q   <= '0;
            tx_q    <= 8'hFF;
            rx_q    <= 8'hFF;
            bit_q   <= '0;
            bytes_q <= '0;
            dout_q  <= 8'hFF;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sdclk_q <= 1'b0;
            sddo_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            bytes_q <= bytes_d;
            dout_q  <= dout_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            cs_n_q  <= cs_n_d;
            sdclk_q <= sdclk_d;
            sddo_q  <= sddo_d;
        end
    end

    assign dout     = dout_q;
    assign dout_stb = stb_q;
    assign busy     = busy_q;
    assign sdcs_n   = cs_n_q;
    assign sdclk    = sdclk_q;
    assign sddo     = sddo_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Scoreboard bench for sd_spi_master. Drivers push the expected received
// bytes (with strobe cycle) and expected MOSI bytes into queues; independent
// monitors pop and compare whenever dout_stb pulses or 8 sdclk rises complete.
module tb_sd_spi_master;

    localparam int DIV_SLOW = 34;
    localparam int DIV_FAST = 0;

    logic       fclk = 1'b0;
    logic       rst_n;
    logic       cs_ctl, speed, start, abort;
    logic [7:0] din;
    logic [9:0] cnt;
    logic [7:0] dout;
    logic       dout_stb, busy, sdcs_n, sdclk, sddo, sddi;

    sd_spi_master #(.DIV_SLOW(DIV_SLOW), .DIV_FAST(DIV_FAST)) dut (
        .fclk(fclk), .rst_n(rst_n), .cs_ctl(cs_ctl), .speed(speed),
        .start(start), .din(din), .cnt(cnt), .abort(abort),
        .dout(dout), .dout_stb(dout_stb), .busy(busy), .sdcs_n(sdcs_n),
        .sdclk(sdclk), .sddo(sddo), .sddi(sddi)
    );

    always #5 fclk = ~fclk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge fclk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- MISO card model ----------------
    logic [7:0]  miso_b [8];
    logic [0:63] mbits;
    int          midx = 0;

    assign sddi = (midx < 64) ? mbits[midx] : 1'b1;

    // Card shifts out its next bit shortly after each rising sdclk.
    always @(posedge sdclk) begin
        #1 midx++;
    end

    task automatic load_miso(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        for (int i = 0; i < 8; i++) miso_b[i] = 8'hFF;
        miso_b[0] = b0;
        miso_b[1] = b1;
        miso_b[2] = b2;
        for (int i = 0; i < 8; i++)
            for (int b = 0; b < 8; b++)
                mbits[i*8 + b] = miso_b[i][7-b];
        midx = 0;
    endtask

    // ---------------- scoreboards ----------------
    typedef struct {
        logic [7:0] data;
        int         at;
        bit         last;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] mosi_q[$];
    logic [7:0] mosi_sh = 8'h00;
    int         mosi_n  = 0;

    // Received-byte monitor: data, strobe cycle and busy on the final strobe.
    always @(negedge fclk) begin
        if (rst_n === 1'b1 && dout_stb === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("stb_unexpected", {31'b0, dout_stb}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("dout", {24'b0, dout}, {24'b0, e.data});
                check("stb_cycle", cyc, e.at);
                check("busy_at_stb", {31'b0, busy}, {31'b0, ~e.last});
            end
        end
    end

    // MOSI monitor: assemble sddo at each rising sdclk into bytes.
    always @(posedge sdclk) begin
        mosi_sh = {mosi_sh[6:0], sddo};
        mosi_n++;
        if (mosi_n == 8) begin
            mosi_n = 0;
            if (mosi_q.size() == 0) check("mosi_extra_byte", mosi_q.size(), 32'd1);
            else check("mosi_byte", {24'b0, mosi_sh}, {24'b0, mosi_q.pop_front()});
        end
    end

    // ---------------- driver helpers ----------------
    task automatic start_xfer(input logic spd, input logic [7:0] d, input int n,
                              input int div, input bit expect_all, output int t);
        mosi_n = 0;
        midx   = 0;
        if (expect_all) begin
            mosi_q.push_back(d);
            for (int k = 0; k < n; k++) mosi_q.push_back(8'hFF);
        end
        @(negedge fclk);
        speed = spd; din = d; cnt = 10'(n); start = 1'b1;
        @(negedge fclk);
        start = 1'b0;
        t = cyc;  // edge at which start was sampled
        if (expect_all)
            for (int k = 0; k <= n; k++)
                exp_q.push_back('{data: miso_b[k], at: t + 16*(div+1)*(k+1), last: (k == n)});
    endtask

    task automatic wait_idle(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc && busy !== 1'b0; i++) @(negedge fclk);
        if (i == max_cyc) check("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_stb_left"}, exp_q.size(), 32'd0);
        check({tag, "_mosi_left"}, mosi_q.size(), 32'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_sdcs_n", {31'b0, sdcs_n}, 32'd1);
        check("rst_sdclk", {31'b0, sdclk}, 32'd0);
        check("rst_sddo", {31'b0, sddo}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_stb", {31'b0, dout_stb}, 32'd0);
        check("rst_dout", {24'b0, dout}, 32'hFF);
    endtask

    // Watchdog: a hung run still reports.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int t, r, f, i, rises;
        bit bad;
        logic [7:0] dout_before;

        for (int k = 0; k < 8; k++) miso_b[k] = 8'hFF;
        mbits = '1;

        // 1. Reset with random inputs, then chip-select follow.
        rst_n  = 1'b0;
        cs_ctl = 1'($urandom); speed = 1'($urandom); start = 1'($urandom);
        abort  = 1'($urandom); din = 8'($urandom);  cnt = 10'($urandom);
        repeat (4) @(negedge fclk);
        check_reset_vals();
        start = 1'b0; abort = 1'b0; cs_ctl = 1'b0; din = 8'h00; cnt = '0; speed = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge fclk);
        cs_ctl = 1'b1;
        #1 check("cs_not_early", {31'b0, sdcs_n}, 32'd1);
        @(negedge fclk);
        check("cs_follow", {31'b0, sdcs_n}, 32'd0);

        // 2. Fast single byte: tx A5, rx 3C.
        load_miso(8'h3C, 8'hFF, 8'hFF);
        start_xfer(1'b1, 8'hA5, 0, DIV_FAST, 1'b1, t);
        wait_idle(100);
        repeat (2) @(negedge fclk);
        check_drained("fast");

        // 3. Slow timing: 35-cycle phases, strobe at T+560.
        load_miso(8'h5A, 8'hFF, 8'hFF);
        start_xfer(1'b0, 8'h81, 0, DIV_SLOW, 1'b1, t);
        for (i = 0; i < 200 && sdclk !== 1'b1; i++) @(negedge fclk);
        r = cyc;
        for (i = 0; i < 200 && sdclk !== 1'b0; i++) @(negedge fclk);
        f = cyc;
        check("slow_high_phase", f - r, 32'd35);
        for (i = 0; i < 200 && sdclk !== 1'b1; i++) @(negedge fclk);
        check("slow_low_phase", cyc - f, 32'd35);
        check("slow_first_rise", r - t, 32'd35);
        wait_idle(700);
        repeat (2) @(negedge fclk);
        check_drained("slow");

        // 4. Burst: tx 40,FF,FF; rx AA,55,0F.
        load_miso(8'hAA, 8'h55, 8'h0F);
        start_xfer(1'b1, 8'h40, 2, DIV_FAST, 1'b1, t);
        while (cyc < t + 47) @(negedge fclk);
        check("burst_busy_t47", {31'b0, busy}, 32'd1);
        wait_idle(100);
        repeat (2) @(negedge fclk);
        check_drained("burst");

        // 5a. start mid-transfer is ignored.
        load_miso(8'h11, 8'h22, 8'hFF);
        start_xfer(1'b1, 8'h12, 1, DIV_FAST, 1'b1, t);
        repeat (5) @(negedge fclk);
        din = 8'hEE; cnt = 10'd3; start = 1'b1;
        @(negedge fclk);
        start = 1'b0;
        wait_idle(100);
        repeat (40) @(negedge fclk);
        check_drained("ignored_start");

        // 5b. cs_ctl dropped mid-burst is deferred until idle.
        load_miso(8'h01, 8'h02, 8'h03);
        start_xfer(1'b1, 8'h33, 2, DIV_FAST, 1'b1, t);
        repeat (10) @(negedge fclk);
        cs_ctl = 1'b0;
        bad = 1'b0;
        for (i = 0; i < 100 && busy === 1'b1; i++) begin
            if (sdcs_n !== 1'b0) bad = 1'b1;
            @(negedge fclk);
        end
        check("cs_held_while_busy", {31'b0, bad}, 32'd0);
        check("cs_at_busy_fall", {31'b0, sdcs_n}, 32'd0);
        @(negedge fclk);
        check("cs_after_idle", {31'b0, sdcs_n}, 32'd1);
        cs_ctl = 1'b1;
        repeat (2) @(negedge fclk);
        check_drained("cs_defer");

        // 6a. Abort after the 3rd rising sdclk of byte 1 in a cnt=5 burst.
        load_miso(8'hF0, 8'hF1, 8'hF2);
        dout_before = dout;
        start_xfer(1'b1, 8'hC3, 5, DIV_FAST, 1'b0, t);
        rises = 0;
        for (i = 0; i < 100 && rises < 3; i++) begin
            if (sdclk === 1'b1) rises++;
            if (rises < 3) @(negedge fclk);
        end
        abort = 1'b1;
        @(negedge fclk);
        abort = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_sdclk", {31'b0, sdclk}, 32'd0);
        check("abort_sddo", {31'b0, sddo}, 32'd1);
        check("abort_dout_kept", {24'b0, dout}, {24'b0, dout_before});
        repeat (60) @(negedge fclk);
        check("abort_busy_stays", {31'b0, busy}, 32'd0);
        check_drained("abort");

        // 6b. Asynchronous reset mid-byte, then a normal transfer.
        load_miso(8'h77, 8'hFF, 8'hFF);
        start_xfer(1'b1, 8'h99, 3, DIV_FAST, 1'b0, t);
        repeat (6) @(negedge fclk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        @(negedge fclk);
        rst_n = 1'b1;
        repeat (2) @(negedge fclk);
        check("cs_after_reset", {31'b0, sdcs_n}, 32'd0);
        load_miso(8'hC3, 8'hFF, 8'hFF);
        start_xfer(1'b1, 8'h5A, 0, DIV_FAST, 1'b1, t);
        wait_idle(100);
        repeat (2) @(negedge fclk);
        check_drained("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
